// File: rtl/seq_detect_frame_ctrl.sv
// Frame controller that scans parallel words MSB-first through a bit-serial 1010
// detector and reports the per-frame match count over a valid/ready handshake.
module seq_detect_frame_ctrl #(
  parameter int WORD_W      = 8,
  parameter int FRAME_WORDS = 4,
  parameter int CNT_W       = 8,
  parameter int DET_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              det_clr,
  output logic              det_en,
  output logic              det_ip,
  input  logic              det_op,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_sat
);

  localparam int BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int WIDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int DRN_W  = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
  localparam logic [WIDX_W-1:0] WORD_LAST = WIDX_W'(FRAME_WORDS - 1);
  localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(DET_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_REPORT = 3'd5
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [WORD_W-1:0]   shreg_r, shreg_nxt_s;
  logic [BIT_W-1:0]    bit_idx_r, bit_nxt_s;
  logic [WIDX_W-1:0]   word_idx_r, word_nxt_s;
  logic [DRN_W-1:0]    drain_cnt_r, drain_nxt_s;
  logic [DET_LAT-1:0]  pipe_r, pipe_nxt_s;
  logic [CNT_W-1:0]    count_r, count_nxt_s;
  logic                sat_r, sat_nxt_s;
  logic                frame_start_s;
  logic                in_hs_s;
  logic                res_hs_s;
  logic                hit_s;

  logic in_ready_r, det_clr_r, det_en_r, det_ip_r, res_valid_r;
  logic in_ready_nxt_s;

  assign in_hs_s  = in_valid & in_ready_r;
  assign res_hs_s = res_valid_r & res_ready;
  assign hit_s    = pipe_r[DET_LAT-1] & det_op;

  // Next-state and datapath decode for the frame sequencer.
  always_comb begin
    state_nxt_s   = state_r;
    shreg_nxt_s   = shreg_r;
    bit_nxt_s     = bit_idx_r;
    word_nxt_s    = word_idx_r;
    drain_nxt_s   = drain_cnt_r;
    frame_start_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_hs_s) begin
          shreg_nxt_s   = in_data;
          word_nxt_s    = {WIDX_W{1'b0}};
          bit_nxt_s     = {BIT_W{1'b0}};
          frame_start_s = 1'b1;
          state_nxt_s   = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_nxt_s = ST_SHIFT;
      end
      ST_SHIFT: begin
        shreg_nxt_s = {shreg_r[WORD_W-2:0], 1'b0};
        if (bit_idx_r == BIT_LAST) begin
          bit_nxt_s = {BIT_W{1'b0}};
          if (word_idx_r == WORD_LAST) begin
            drain_nxt_s = {DRN_W{1'b0}};
            state_nxt_s = ST_DRAIN;
          end else if (in_hs_s) begin
            // Next word arrives on the last bit: continue without a bubble.
            shreg_nxt_s = in_data;
            word_nxt_s  = word_idx_r + WIDX_W'(1);
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end else begin
          bit_nxt_s = bit_idx_r + BIT_W'(1);
        end
      end
      ST_WAIT: begin
        if (in_hs_s) begin
          shreg_nxt_s = in_data;
          word_nxt_s  = word_idx_r + WIDX_W'(1);
          bit_nxt_s   = {BIT_W{1'b0}};
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == DRN_LAST) begin
          state_nxt_s = ST_REPORT;
        end else begin
          drain_nxt_s = drain_cnt_r + DRN_W'(1);
        end
      end
      ST_REPORT: begin
        if (res_hs_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REPORT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Producer-side ready, decoded from the upcoming state so the output is registered.
  always_comb begin
    in_ready_nxt_s = 1'b0;
    if ((state_nxt_s == ST_IDLE) || (state_nxt_s == ST_WAIT)) begin
      in_ready_nxt_s = 1'b1;
    end else if ((state_nxt_s == ST_SHIFT) && (bit_nxt_s == BIT_LAST) &&
                 (word_nxt_s < WORD_LAST)) begin
      in_ready_nxt_s = 1'b1;
    end else begin
      in_ready_nxt_s = 1'b0;
    end
  end

  // Delay line of det_en marking which det_op cycles belong to a shifted bit.
  always_comb begin
    pipe_nxt_s    = pipe_r;
    pipe_nxt_s[0] = det_en_r;
    for (int i = 1; i < DET_LAT; i++) begin
      pipe_nxt_s[i] = pipe_r[i-1];
    end
  end

  // Saturating match counter, cleared at frame start.
  always_comb begin
    count_nxt_s = count_r;
    sat_nxt_s   = sat_r;
    if (frame_start_s) begin
      count_nxt_s = {CNT_W{1'b0}};
      sat_nxt_s   = 1'b0;
    end else if (hit_s) begin
      if (count_r == CNT_MAX) begin
        sat_nxt_s = 1'b1;
      end else begin
        count_nxt_s = count_r + CNT_W'(1);
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      shreg_r     <= {WORD_W{1'b0}};
      bit_idx_r   <= {BIT_W{1'b0}};
      word_idx_r  <= {WIDX_W{1'b0}};
      drain_cnt_r <= {DRN_W{1'b0}};
      pipe_r      <= {DET_LAT{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      sat_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      shreg_r     <= shreg_nxt_s;
      bit_idx_r   <= bit_nxt_s;
      word_idx_r  <= word_nxt_s;
      drain_cnt_r <= drain_nxt_s;
      pipe_r      <= pipe_nxt_s;
      count_r     <= count_nxt_s;
      sat_r       <= sat_nxt_s;
    end
  end

  // Output registers, loaded from the upcoming state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_r  <= 1'b1;
      det_clr_r   <= 1'b0;
      det_en_r    <= 1'b0;
      det_ip_r    <= 1'b0;
      res_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_nxt_s;
      det_clr_r   <= (state_nxt_s == ST_CLEAR);
      det_en_r    <= (state_nxt_s == ST_SHIFT);
      det_ip_r    <= (state_nxt_s == ST_SHIFT) & shreg_nxt_s[WORD_W-1];
      res_valid_r <= (state_nxt_s == ST_REPORT);
    end
  end

  assign in_ready  = in_ready_r;
  assign det_clr   = det_clr_r;
  assign det_en    = det_en_r;
  assign det_ip    = det_ip_r;
  assign res_valid = res_valid_r;
  assign res_count = count_r;
  assign res_sat   = sat_r;

endmodule

// File: tb/tb_seq_detect_frame_ctrl.sv
// Bench for seq_detect_frame_ctrl: two instances (8-bit and 2-bit counters) in lockstep,
// each driving a behavioural 1010 Moore detector; frame results checked via a scoreboard.
module tb_seq_detect_frame_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       res_ready;

  logic       in_ready_a, det_clr_a, det_en_a, det_ip_a, det_op_a, res_valid_a, res_sat_a;
  logic [7:0] res_count_a;
  logic       in_ready_b, det_clr_b, det_en_b, det_ip_b, det_op_b, res_valid_b, res_sat_b;
  logic [1:0] res_count_b;

  logic [2:0] det_st_a, det_st_b;

  seq_detect_frame_ctrl #(.WORD_W(8), .FRAME_WORDS(2), .CNT_W(8), .DET_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .det_clr(det_clr_a), .det_en(det_en_a), .det_ip(det_ip_a), .det_op(det_op_a),
    .res_valid(res_valid_a), .res_ready(res_ready), .res_count(res_count_a), .res_sat(res_sat_a)
  );

  seq_detect_frame_ctrl #(.WORD_W(8), .FRAME_WORDS(2), .CNT_W(2), .DET_LAT(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .det_clr(det_clr_b), .det_en(det_en_b), .det_ip(det_ip_b), .det_op(det_op_b),
    .res_valid(res_valid_b), .res_ready(res_ready), .res_count(res_count_b), .res_sat(res_sat_b)
  );

  function automatic logic [2:0] det_next(input logic [2:0] s, input logic b);
    case (s)
      3'd0:    det_next = b ? 3'd1 : 3'd0;
      3'd1:    det_next = b ? 3'd1 : 3'd2;
      3'd2:    det_next = b ? 3'd3 : 3'd0;
      3'd3:    det_next = b ? 3'd1 : 3'd4;
      3'd4:    det_next = b ? 3'd3 : 3'd0;
      default: det_next = 3'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst)          det_st_a <= 3'd0;
    else if (det_clr_a) det_st_a <= 3'd0;
    else if (det_en_a)  det_st_a <= det_next(det_st_a, det_ip_a);
  end

  always @(posedge clk or negedge rst) begin
    if (!rst)          det_st_b <= 3'd0;
    else if (det_clr_b) det_st_b <= 3'd0;
    else if (det_en_b)  det_st_b <= det_next(det_st_b, det_ip_b);
  end

  assign det_op_a = (det_st_a == 3'd4);
  assign det_op_b = (det_st_b == 3'd4);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] w0;
    logic [7:0] w1;
    int         gap;
    int         hold;
    int         cnt_a;
    int         cnt_b;
    int         sat_b;
  } vec_t;

  typedef struct {
    int cnt_a;
    int cnt_b;
    int sat_b;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int en_cnt, clr_cnt, ipbad, first_en, last_en, first_rv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (det_en_a) begin
      if (en_cnt == 0) first_en = cyc;
      last_en = cyc;
      en_cnt++;
    end
    if (det_clr_a) clr_cnt++;
    if (det_ip_a && !det_en_a) ipbad++;
    if (res_valid_a && first_rv < 0) first_rv = cyc;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!in_ready_a && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready_a) begin
      tests++;
      fails++;
      $display("FAIL %s: in_ready=0 after 100 cycles, expected 1", nm);
    end
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int         h;
    int         n;
    logic [7:0] held;
    logic       ok;
    exp_t       e;
    en_cnt = 0; clr_cnt = 0; ipbad = 0; first_en = -1; last_en = -1; first_rv = -1;
    in_valid = 1'b1;
    in_data  = v.w0;
    wait_ready($sformatf("f%0d_w0_ready", idx));
    h = cyc;
    tick();
    in_valid = 1'b0;
    if (v.gap == 0) begin
      in_valid = 1'b1;
      in_data  = v.w1;
      wait_ready($sformatf("f%0d_w1_ready", idx));
    end else begin
      wait_ready($sformatf("f%0d_lastbit_ready", idx));
      tick();
      repeat (v.gap - 1) tick();
      in_valid = 1'b1;
      in_data  = v.w1;
      chk($sformatf("f%0d_wait_in_ready", idx), in_ready_a, 1);
    end
    sb.push_back('{v.cnt_a, v.cnt_b, v.sat_b});
    tick();
    in_valid = 1'b0;

    res_ready = 1'b0;
    n = 0;
    while (!res_valid_a && n < 100) begin
      tick();
      n++;
    end
    chk($sformatf("f%0d_res_valid", idx), res_valid_a, 1);
    chk($sformatf("f%0d_rpt_in_ready", idx), in_ready_a, 0);
    held = res_count_a;
    ok = 1'b1;
    for (int k = 0; k < v.hold; k++) begin
      tick();
      if (!res_valid_a || res_count_a !== held || res_sat_a !== 1'b0 || in_ready_a) ok = 1'b0;
    end
    chk($sformatf("f%0d_hold_stable", idx), ok, 1);

    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL f%0d_scoreboard: got empty queue expected 1 entry", idx);
    end else begin
      e = sb.pop_front();
      chk($sformatf("f%0d_count_a", idx), res_count_a, e.cnt_a);
      chk($sformatf("f%0d_sat_a", idx), res_sat_a, 0);
      chk($sformatf("f%0d_count_b", idx), res_count_b, e.cnt_b);
      chk($sformatf("f%0d_sat_b", idx), res_sat_b, e.sat_b);
    end
    chk($sformatf("f%0d_en_cycles", idx), en_cnt, 16);
    chk($sformatf("f%0d_en_span", idx), last_en - first_en + 1, 16 + v.gap);
    chk($sformatf("f%0d_accept_to_en", idx), first_en - h, 2);
    chk($sformatf("f%0d_clr_pulses", idx), clr_cnt, 1);
    chk($sformatf("f%0d_ip_without_en", idx), ipbad, 0);
    chk($sformatf("f%0d_lastbit_to_valid", idx), first_rv - last_en, 2);

    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk($sformatf("f%0d_post_valid", idx), res_valid_a, 0);
    chk($sformatf("f%0d_post_in_ready", idx), in_ready_a, 1);
  endtask

  initial begin
    vecs[0] = '{8'hAA, 8'hAA, 0, 0,  7, 3, 1};
    vecs[1] = '{8'h0A, 8'hA0, 0, 0,  3, 3, 0};
    vecs[2] = '{8'h0A, 8'hA0, 5, 0,  3, 3, 0};
    vecs[3] = '{8'h00, 8'h05, 0, 0,  0, 0, 0};
    vecs[4] = '{8'h00, 8'h00, 0, 0,  0, 0, 0};
    vecs[5] = '{8'hAA, 8'hAA, 0, 10, 7, 3, 1};
    vecs[6] = '{8'h55, 8'h55, 0, 0,  6, 3, 1};
    vecs[7] = '{8'hFF, 8'hFF, 0, 0,  0, 0, 0};

    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; res_ready = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready",  in_ready_a,  1);
    chk("rst_det_en",    det_en_a,    0);
    chk("rst_det_clr",   det_clr_a,   0);
    chk("rst_det_ip",    det_ip_a,    0);
    chk("rst_res_valid", res_valid_a, 0);
    chk("rst_res_count", res_count_a, 0);
    chk("rst_res_sat",   res_sat_a,   0);
    chk("rst_count_b",   res_count_b, 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_frame(vecs[i], i);

    // Abort a frame with reset while the second word is shifting.
    in_valid = 1'b1;
    in_data  = 8'hAA;
    wait_ready("mid_w0_ready");
    tick();
    in_data = 8'hAA;
    wait_ready("mid_w1_ready");
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("mid_shift_en", det_en_a, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready",  in_ready_a,  1);
    chk("mid_rst_res_valid", res_valid_a, 0);
    chk("mid_rst_det_en",    det_en_a,    0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    repeat (6) tick();
    chk("mid_no_result", res_valid_a, 0);
    chk("mid_in_ready",  in_ready_a,  1);
    run_frame(vecs[0], 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_detect_frame_ctrl.md
Name: seq_detect_frame_ctrl

Overview:
Frame controller that sequences a bit-serial Moore sequence detector (pattern 1010, overlapping matches) over parallel input data.
- Accepts WORD_W-bit words over a valid/ready handshake.
- Clears the detector at each frame start, then shifts each word out MSB-first, one bit per enabled cycle.
- Counts detector hits per frame of FRAME_WORDS words and reports the count over a second valid/ready handshake.
- Sits between the word-level producer and the detector instance.

Parameters:
WORD_W, 8, bits per input word
FRAME_WORDS, 4, words per frame (>=1)
CNT_W, 8, width of match counter
DET_LAT, 1, cycles from det_ip/det_en sample to the corresponding det_op (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  producer word valid
in_ready  output  1  controller accepts word when in_valid&in_ready
in_data  input  WORD_W  word to scan, MSB shifted first
det_clr  output  1  one-cycle synchronous clear of detector state to s0
det_en  output  1  detector advances on det_ip this cycle
det_ip  output  1  serial bit to detector
det_op  input  1  detector match output
res_valid  output  1  frame result available
res_ready  input  1  consumer takes result
res_count  output  CNT_W  matches in frame
res_sat  output  1  count saturated

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. in_ready=1, all other outputs 0, counters, shift register and latency pipe cleared. Reset mid-frame aborts the frame; no result is produced.
- States: IDLE, CLEAR, SHIFT, WAIT, DRAIN, REPORT.
- IDLE:
  - in_ready=1.
  - On handshake: load shreg=in_data, word_idx=0, count=0, res_sat=0, then go to CLEAR.
- CLEAR:
  - One cycle. det_clr=1, det_en=0, in_ready=0. Next state SHIFT.
- SHIFT:
  - det_en=1, det_ip=shreg MSB. shreg shifts left each cycle; bit_idx counts 0..WORD_W-1.
  - in_ready=1 only on bit_idx==WORD_W-1 AND word_idx<FRAME_WORDS-1.
  - On the last bit with handshake: load the next word, word_idx+1, bit_idx=0, stay in SHIFT (no bubble).
  - On the last bit, no handshake, more words due: go to WAIT.
  - On the last bit of the last word: go to DRAIN.
- WAIT:
  - det_en=0 (detector holds state; matches may span words across stalls). in_ready=1.
  - On handshake: load word, word_idx+1, go to SHIFT.
- DRAIN:
  - det_en=0. Lasts exactly DET_LAT cycles, then go to REPORT.
- Counting:
  - A DET_LAT-deep pipe of det_en marks det_op cycles that correspond to a shifted bit.
  - count increments when pipe output=1 and det_op=1, in any state.
  - count saturates at 2^CNT_W-1; an increment attempted at max sets res_sat=1.
- REPORT:
  - res_valid=1, res_count/res_sat held stable until res_ready. in_ready=0.
  - On handshake: go to IDLE, res_valid=0 next cycle.
- Cross-frame isolation: det_clr at every frame start, so no match spans frames.
- Latency: first word accept -> first det_en = 2 cycles. Last bit -> res_valid = DET_LAT+1 cycles.
- det_ip=0 whenever det_en=0.
- in_valid while in_ready=0 is ignored; the producer holds the word.

Test Plan:
- Defaults with FRAME_WORDS=2. Words 0xAA,0xAA back-to-back -> det_en high 16 consecutive cycles, res_count=7, res_sat=0, res_valid asserted 2 cycles after last det_en.
- FRAME_WORDS=2. Words 0x0A,0xA0 -> res_count=3, including the match spanning the word boundary.
- Repeat 0x0A,0xA0 with in_valid held low 5 cycles between words -> WAIT for 5 cycles with det_en=0, res_count=3 unchanged.
- Frame1 0x00,0x05 -> count 0. Frame2 0x00,0x00 -> count 0. det_clr pulses once per frame; no carry of the trailing "101".
- CNT_W=2. Words 0xAA,0xAA -> res_count=3, res_sat=1.
- rst low mid-SHIFT of word 1 -> next cycle IDLE, in_ready=1, res_valid=0. A following frame 0xAA,0xAA -> res_count=7.
- res_ready held low 10 cycles in REPORT -> res_valid, res_count stable. in_ready=0 throughout.
